// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// FSM state encoding, requester ids and the ALU control codes.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

endpackage

// File: rtl/alu_share_ctrl_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// a tie goes to the requester that was not granted last.
module rr_pick2
  import alu_share_ctrl_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = valid0 | valid1;
    if (valid0 && valid1) gnt_id = ~last;
    else if (valid1)      gnt_id = REQ1;
    else                  gnt_id = REQ0;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional `ALU_SHARE_ZERO_EN adds a registered rsp_zero flag next to rsp_data.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTL_W  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CTL_W-1:0] req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTL_W-1:0] req1_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_SHARE_ZERO_EN
  output logic             rsp_zero,
`endif
  output logic             busy
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       id;
  logic [3:0] cnt;
  logic       gnt_valid, gnt_id;
  logic       grant, rsp_hs, sample;

  rr_pick2 u_pick (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    grant      = 1'b0;
    rsp_hs     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        // Ready is suppressed while reset is held so nothing looks accepted.
        grant      = gnt_valid && !reset;
        req0_ready = grant && (gnt_id == REQ0);
        req1_ready = grant && (gnt_id == REQ1);
        if (grant) state_nxt = EXEC;
      end
      EXEC: begin
        sample = (cnt == 4'd0);
        if (sample) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = (id == REQ0);
        rsp1_valid = (id == REQ1);
        rsp_hs     = (id == REQ1) ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ1;
      id         <= REQ0;
      cnt        <= 4'd0;
    end else begin
      if (grant) begin
        id  <= gnt_id;
        cnt <= CNT_INIT;
      end else if (state == EXEC && !sample) begin
        cnt <= cnt - 4'd1;
      end
      if (rsp_hs) last_grant <= id;
    end
  end

  // ALU operand registers hold between operations; result captured on the last settle cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctl  <= '0;
      rsp_data <= '0;
`ifdef ALU_SHARE_ZERO_EN
      rsp_zero <= 1'b0;
`endif
    end else begin
      if (grant) begin
        alu_a   <= (gnt_id == REQ1) ? req1_a   : req0_a;
        alu_b   <= (gnt_id == REQ1) ? req1_b   : req0_b;
        alu_ctl <= (gnt_id == REQ1) ? req1_ctl : req0_ctl;
      end
      if (sample) begin
        rsp_data <= alu_result;
`ifdef ALU_SHARE_ZERO_EN
        rsp_zero <= (alu_result == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a behavioural ALU as the shared datapath and a
// transaction-level reference model; `ALU_SHARE_ZERO_EN also exercises rsp_zero.
module tb_alu_share_ctrl;

  localparam int SETTLE = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data;
  logic [3:0]  alu_ctl;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, busy;
  logic        zero_flag;

  alu_share_ctrl #(.WIDTH(32), .CTL_W(4), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
`ifdef ALU_SHARE_ZERO_EN
    .rsp_zero(zero_flag),
`endif
    .busy(busy)
  );
`ifndef ALU_SHARE_ZERO_EN
  assign zero_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctl);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Requester agents: pending op queues, optional random cancel and response backpressure.
  op_t q0[$], q1[$];
  bit  rand_mode = 0;
  bit  hold0 = 1, hold1 = 1;
  logic acc0, acc1;

  initial begin : agent
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_ctl = 0; req1_a = 0; req1_b = 0; req1_ctl = 0;
    forever begin
      @(negedge clk); #1;
      acc0 = req0_ready; acc1 = req1_ready;
      @(posedge clk); #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0 && !(rand_mode && $urandom_range(0, 7) == 0)) begin
        req0_valid = 1; req0_a = q0[0].a; req0_b = q0[0].b; req0_ctl = q0[0].ctl;
      end else req0_valid = 0;
      if (q1.size() > 0 && !(rand_mode && $urandom_range(0, 7) == 0)) begin
        req1_valid = 1; req1_a = q1[0].a; req1_b = q1[0].b; req1_ctl = q1[0].ctl;
      end else req1_valid = 0;
      rsp0_ready = rand_mode ? ($urandom_range(0, 2) != 0) : hold0;
      rsp1_ready = rand_mode ? ($urandom_range(0, 2) != 0) : hold1;
    end
  end

  // Reference model: an owner plus its age in cycles since acceptance.
  int          m_owner, m_age, win;
  bit          m_last;
  logic [31:0] m_a, m_b, m_rsp;
  logic [3:0]  m_ctl;
  logic        m_zero, rv;
  int          g_id[$], g_cyc[$], r_id[$], r_cyc[$];
  logic [31:0] r_data[$];
  logic        r_zero[$];

  initial begin : model_chk
    forever begin
      @(negedge clk);
      if (reset) begin
        m_owner = -1; m_age = 0; m_last = 1;
        m_a = 0; m_b = 0; m_ctl = 0; m_rsp = 0; m_zero = 0;
        continue;
      end
      win = -1;
      if (m_owner < 0) begin
        if (req0_valid && req1_valid) win = m_last ? 0 : 1;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end
      rv = (m_owner >= 0) && (m_age > SETTLE);
      chk("req0_ready", req0_ready, win == 0);
      chk("req1_ready", req1_ready, win == 1);
      chk("rsp0_valid", rsp0_valid, rv && m_owner == 0);
      chk("rsp1_valid", rsp1_valid, rv && m_owner == 1);
      chk("busy", busy, m_owner >= 0);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_ctl", alu_ctl, m_ctl);
      chk("rsp_data", rsp_data, m_rsp);
`ifdef ALU_SHARE_ZERO_EN
      chk("rsp_zero", zero_flag, m_zero);
`endif
      if (win >= 0) begin
        m_owner = win; m_age = 1;
        m_a = win ? req1_a : req0_a; m_b = win ? req1_b : req0_b; m_ctl = win ? req1_ctl : req0_ctl;
        g_id.push_back(win); g_cyc.push_back(cyc);
      end else if (m_owner >= 0 && m_age <= SETTLE) begin
        if (m_age == SETTLE) begin
          m_rsp = alu_fn(m_a, m_b, m_ctl);
          m_zero = (m_rsp == 0);
        end
        m_age++;
      end else if (rv && (m_owner ? rsp1_ready : rsp0_ready)) begin
        r_id.push_back(m_owner); r_cyc.push_back(cyc); r_data.push_back(rsp_data); r_zero.push_back(zero_flag);
        m_last = (m_owner == 1);
        m_owner = -1;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy || req0_valid || req1_valid) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_timeout", n >= budget, 0);
  endtask

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    op_t o;
    o.a = a; o.b = b; o.ctl = c;
    return o;
  endfunction

  initial begin : tests
    int gb, rb, n;
    bit seen;
    logic [3:0] ctls [6];
    ctls[0] = 4'b0000; ctls[1] = 4'b0001; ctls[2] = 4'b0010;
    ctls[3] = 4'b0110; ctls[4] = 4'b0111; ctls[5] = 4'b0011;

    reset = 1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctl", alu_ctl, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    // Both requesters valid straight out of reset: requester 0 first.
    q0.push_back(mk(32'd10, 32'd4, 4'b0110));
    q1.push_back(mk(32'hF0, 32'h3C, 4'b0000));
    repeat (3) @(posedge clk);
    #1 reset = 0;
    gb = g_id.size(); rb = r_id.size();
    wait_idle(100);
    chk("both_g0", g_id[gb], 0);
    chk("both_g1", g_id[gb+1], 1);
    chk("both_gap", g_cyc[gb+1] - g_cyc[gb], 4);
    chk("both_r0", r_data[rb], 32'd6);
    chk("both_r1", r_data[rb+1], 32'h30);
    chk("both_rid1", r_id[rb+1], 1);

    // Continuous contention: strict alternation.
    gb = g_id.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(i, 1, 4'b0010));
      q1.push_back(mk(i, 2, 4'b0010));
    end
    wait_idle(200);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), g_id[gb+i], i % 2);

    // Single op latency.
    gb = g_id.size(); rb = r_id.size();
    q0.push_back(mk(32'd5, 32'd3, 4'b0010));
    wait_idle(100);
    chk("single_data", r_data[rb], 32'd8);
    chk("single_id", r_id[rb], 0);
    chk("single_lat", r_cyc[rb] - g_cyc[gb], SETTLE + 1);

    // Response backpressure on requester 1.
    hold1 = 0;
    rb = r_id.size();
    q1.push_back(mk(32'h0F, 32'hF0, 4'b0001));
    n = 0;
    while (!rsp1_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_timeout", n >= 20, 0);
    q0.push_back(mk(32'd2, 32'd2, 4'b0010));
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_valid", rsp1_valid, 1);
      chk("bp_data", rsp_data, 32'hFF);
      chk("bp_busy", busy, 1);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    hold1 = 1;
    wait_idle(100);
    chk("bp_r0", r_data[rb], 32'hFF);
    chk("bp_r1", r_data[rb+1], 32'd4);

    // Reset in the middle of EXEC aborts silently.
    gb = g_id.size(); rb = r_id.size();
    q0.push_back(mk(32'd5, 32'd3, 4'b0010));
    n = 0;
    while (g_id.size() == gb && n < 20) begin @(negedge clk); #1; n++; end
    chk("abort_grant_timeout", n >= 20, 0);
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_rsp_data", rsp_data, 0);
    @(posedge clk); #1 reset = 0;
    #1 chk("abort_busy_after", busy, 0);
    seen = 0;
    repeat (8) begin @(negedge clk); #1; seen |= rsp0_valid; end
    chk("abort_no_rsp", seen, 0);
    chk("abort_no_hs", r_id.size(), rb);

`ifdef ALU_SHARE_ZERO_EN
    rb = r_id.size();
    q1.push_back(mk(32'd7, 32'd7, 4'b0110));
    wait_idle(100);
    q1.push_back(mk(32'd1, 32'd1, 4'b0010));
    wait_idle(100);
    chk("zero_data", r_data[rb], 0);
    chk("zero_flag1", r_zero[rb], 1);
    chk("zero_data2", r_data[rb+1], 32'd2);
    chk("zero_flag0", r_zero[rb+1], 0);
`endif

    // Randomized traffic with cancellation and random backpressure.
    rand_mode = 1;
    rb = r_id.size();
    for (int i = 0; i < 40; i++) begin
      op_t o;
      o.a = ($urandom_range(0, 3) == 0) ? 32'd9 : $urandom;
      o.b = ($urandom_range(0, 3) == 0) ? 32'd9 : $urandom;
      o.ctl = ctls[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 0) q0.push_back(o); else q1.push_back(o);
    end
    wait_idle(4000);
    rand_mode = 0;
    chk("rand_count", r_id.size() - rb, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
